bios_loader: RTL

Parametrised successor to the single-file boot block. It scans the HD image for a `HD_HEAD ... HD_END` region and records a start/end page table for up to `DEPTH` files in an internal table. It then forwards POST firmware instructions to the core until `HALT`, after which it forces `JUMP 0` and drops `bios_active`. It sits between the HD/POST instruction sources and the core fetch mux.

---
 rtl/bios_loader_if.sv | 46 ++++
 rtl/bios_loader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bios_loader_if.sv
`default_nettype none
// ============================================================================
// Module : bios_loader_if
// Brief  : HD/POST instruction sources, fetch output and page-table ports of bios_loader.
// Rev    : 1.0
// ============================================================================
interface bios_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [5:0]        opcode;
    logic              step;
    logic [31:0]       post_instr;
    logic [31:0]       bios_instr;
    logic              bios_active;
    logic [ADDR_W-1:0] pc_hd;
    logic              page_wr;
    logic [IDX_W-1:0]  page_idx;
    logic [ADDR_W-1:0] page_start;
    logic [ADDR_W-1:0] page_end;
    logic [CNT_W-1:0]  file_count;
    logic              overflow;
    logic              scan_err;
    logic [IDX_W-1:0]  lookup_idx;
    logic [ADDR_W-1:0] lookup_start;
    logic [ADDR_W-1:0] lookup_end;
    logic              lookup_hit;

    modport master (
        output opcode, step, post_instr, lookup_idx,
        input  bios_instr, bios_active, pc_hd, page_wr, page_idx, page_start,
               page_end, file_count, overflow, scan_err, lookup_start,
               lookup_end, lookup_hit
    );

    modport slave (
        input  opcode, step, post_instr, lookup_idx,
        output bios_instr, bios_active, pc_hd, page_wr, page_idx, page_start,
               page_end, file_count, overflow, scan_err, lookup_start,
               lookup_end, lookup_hit
    );
endinterface
`default_nettype wire

// File: rtl/bios_loader.sv
`default_nettype none
// ============================================================================
// Module : bios_loader
// Brief  : Scans the HD image for file regions into a page table, then feeds POST
//          code to the core until HALT. Table storage built only with BIOS_LOOKUP_EN.
// Rev    : 1.0
// ============================================================================
module bios_loader #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    bios_loader_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [5:0]  c_BEGIN_FILE = 6'b010101;
    localparam logic [5:0]  c_END_FILE   = 6'b010110;
    localparam logic [5:0]  c_HD_HEAD    = 6'b010111;
    localparam logic [5:0]  c_HD_END     = 6'b011000;
    localparam logic [5:0]  c_HALT       = 6'b011001;
    localparam logic [31:0] c_JUMP0      = 32'h1400_0000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_IN_FILE = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_hd_q, pc_hd_d;
    logic [ADDR_W-1:0] start_q;
    logic [CNT_W-1:0]  file_count_q;
    logic              page_wr_q;
    logic [IDX_W-1:0]  page_idx_q;
    logic [ADDR_W-1:0] page_start_q, page_end_q;
    logic              overflow_q, scan_err_q, bios_active_q;

    logic w_pc_wrap, w_table_full, w_halt, w_scanning;

    assign pc_hd_d      = pc_hd_q + ADDR_W'(1);
    assign w_pc_wrap    = &pc_hd_q;
    assign w_table_full = (file_count_q == CNT_W'(DEPTH));
    assign w_halt       = (bus.post_instr[31:26] == c_HALT);
    assign w_scanning   = (state_q == S_SCAN) || (state_q == S_IN_FILE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_hd_q       <= '0;
            start_q       <= '0;
            file_count_q  <= '0;
            page_wr_q     <= 1'b0;
            page_idx_q    <= '0;
            page_start_q  <= '0;
            page_end_q    <= '0;
            overflow_q    <= 1'b0;
            scan_err_q    <= 1'b0;
            bios_active_q <= 1'b1;
        end else begin
            page_wr_q <= 1'b0;
            if (bus.step && w_scanning) begin
                pc_hd_q <= pc_hd_d;
                if (w_pc_wrap) overflow_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.step && bus.opcode == c_HD_HEAD) state_q <= S_SCAN;
                end
                S_SCAN: begin
                    if (bus.step) begin
                        case (bus.opcode)
                            c_BEGIN_FILE: begin
                                start_q <= pc_hd_q;
                                state_q <= S_IN_FILE;
                            end
                            c_END_FILE: scan_err_q <= 1'b1;
                            c_HD_END:   state_q    <= S_POST;
                            default:    ;
                        endcase
                    end
                end
                S_IN_FILE: begin
                    if (bus.step) begin
                        case (bus.opcode)
                            c_END_FILE: begin
                                // A full table drops the file but the scan carries on.
                                if (w_table_full) begin
                                    overflow_q <= 1'b1;
                                end else begin
                                    page_wr_q    <= 1'b1;
                                    page_idx_q   <= file_count_q[IDX_W-1:0];
                                    page_start_q <= start_q;
                                    page_end_q   <= pc_hd_q;
                                    file_count_q <= file_count_q + CNT_W'(1);
                                end
                                state_q <= S_SCAN;
                            end
                            c_BEGIN_FILE: begin
                                start_q    <= pc_hd_q;
                                scan_err_q <= 1'b1;
                            end
                            c_HD_END: begin
                                scan_err_q <= 1'b1;
                                state_q    <= S_POST;
                            end
                            default: ;
                        endcase
                    end
                end
                S_POST: begin
                    if (w_halt) begin
                        state_q       <= S_DONE;
                        bios_active_q <= 1'b0;
                    end
                end
                S_DONE:  ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.bios_instr  = (state_q == S_POST && !w_halt) ? bus.post_instr : c_JUMP0;
    assign bus.bios_active = bios_active_q;
    assign bus.pc_hd       = pc_hd_q;
    assign bus.page_wr     = page_wr_q;
    assign bus.page_idx    = page_idx_q;
    assign bus.page_start  = page_start_q;
    assign bus.page_end    = page_end_q;
    assign bus.file_count  = file_count_q;
    assign bus.overflow    = overflow_q;
    assign bus.scan_err    = scan_err_q;

`ifdef BIOS_LOOKUP_EN
    logic [ADDR_W-1:0] tab_start_q [DEPTH];
    logic [ADDR_W-1:0] tab_end_q   [DEPTH];
    logic              w_tab_we;
    logic              w_lookup_hit;

    assign w_tab_we = (state_q == S_IN_FILE) && bus.step &&
                      (bus.opcode == c_END_FILE) && !w_table_full;

    // Storage carries no reset; file_count alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (w_tab_we) begin
            tab_start_q[file_count_q[IDX_W-1:0]] <= start_q;
            tab_end_q[file_count_q[IDX_W-1:0]]   <= pc_hd_q;
        end
    end

    assign w_lookup_hit     = (CNT_W'(bus.lookup_idx) < file_count_q);
    assign bus.lookup_hit   = w_lookup_hit;
    assign bus.lookup_start = w_lookup_hit ? tab_start_q[bus.lookup_idx] : '0;
    assign bus.lookup_end   = w_lookup_hit ? tab_end_q[bus.lookup_idx]   : '0;
`else
    logic w_unused_lookup;
    assign w_unused_lookup  = ^bus.lookup_idx;
    assign bus.lookup_hit   = 1'b0;
    assign bus.lookup_start = '0;
    assign bus.lookup_end   = '0;
`endif
endmodule
`default_nettype wire
